debounce_filter: RTL

- Single-bit input conditioning stage that sits directly upstream of the delay stage and drives that stage's i_d.
- Synchronises a raw asynchronous level and rejects glitches shorter than STABLE_CYCLES.
- Emits a clean filtered level plus one-cycle rise/fall strobes for downstream consumers.

---
 rtl/debounce_pkg.sv | 28 ++
 rtl/sync_ff.sv | 33 +++
 rtl/debounce_filter.sv | 119 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types, defaults and counter sizing for debounce_filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_e;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 4;

    // Counter must be able to hold STABLE_CYCLES itself; never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        if (cycles < 1) begin
            return 1;
        end
        return (cycles + 1 > 2) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module      : sync_ff
// Description : Parameterised multi-flop synchroniser chain; last stage is out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES*WIDTH-1:0] chain_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chain_q <= {STAGES{RESET_VALUE}};
        end else begin
            chain_q <= {chain_q[(STAGES-1)*WIDTH-1:0], i_d};
        end
    end

    assign o_q = chain_q[STAGES*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/debounce_filter.sv
// ============================================================================
// Module      : debounce_filter
// Description : Synchronises a raw level, rejects glitches shorter than
//               STABLE_CYCLES and emits filtered level plus edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_filter
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    input  logic i_en,
    output logic o_d,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int                c_cnt_w    = cnt_width(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               w_synced;
    state_e             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               d_q, d_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;

    sync_ff #(
        .WIDTH       (1),
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_d),
        .o_q   (w_synced)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            d_q     <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!i_en) begin
            // Disabling discards any qualification; o_d is frozen.
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (w_synced == d_q) begin
                        cnt_d = '0;
                    end else if (STABLE_CYCLES <= 1) begin
                        d_d    = ~d_q;
                        rise_d = ~d_q;
                        fall_d = d_q;
                        cnt_d  = '0;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = c_cnt_one;
                    end
                end
                QUALIFY: begin
                    if (w_synced == d_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= c_cnt_last) begin
                        d_d     = ~d_q;
                        rise_d  = ~d_q;
                        fall_d  = d_q;
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q != {c_cnt_w{1'b1}}) begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_d    = d_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;
    assign o_busy = (state_q == QUALIFY);

endmodule

`default_nettype wire
